// File: rtl/multu_seq_if.sv
// multu_seq_if: request/result and ALU hookup signals of the sequential multiplier
//   start, dataA, dataB      : multiply request and operands
//   busy, done, hi, lo       : status and 64-bit product
//   alu_ctl/a/b/cin          : drive into the shared ripple ALU
//   alu_result, alu_carry    : sum and carry-out back from the ALU
//   slave modport = multiplier, master modport = requester plus ALU
interface multu_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport slave (
        input  start, dataA, dataB, alu_result, alu_carry,
        output alu_ctl, alu_a, alu_b, alu_cin, busy, done, hi, lo
    );
    modport master (
        output start, dataA, dataB, alu_result, alu_carry,
        input  alu_ctl, alu_a, alu_b, alu_cin, busy, done, hi, lo
    );
endinterface

// File: rtl/multu_seq.sv
// multu_seq: sequential unsigned WIDTHxWIDTH shift-add multiplier using an external ALU as adder
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : multu_seq_if slave (start/dataA/dataB in, busy/done/hi/lo out, ALU drive and return)
module multu_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [5:0] ADD_CTL = 6'd32
) (
    input logic         clk,
    input logic         reset,
    multu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    assign bus.alu_ctl = ADD_CTL;
    assign bus.alu_cin = 1'b0;
    assign bus.alu_a   = (state == RUN) ? hi : '0;
    assign bus.alu_b   = (state == RUN && lo[0]) ? mcand : '0;
    assign bus.hi      = hi;
    assign bus.lo      = lo;
    assign bus.busy    = busy;
    assign bus.done    = done;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= RUN;
                    mcand <= bus.dataA;
                    lo    <= bus.dataB;
                    hi    <= '0;
                    count <= '0;
                    busy  <= 1'b1;
                end
                RUN: begin
                    // 65-bit {carry,sum,lo} shifted right; the carry becomes hi's MSB
                    {hi, lo} <= {bus.alu_carry, bus.alu_result, lo[WIDTH-1:1]};
                    count    <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multu_seq.sv
// tb_multu_seq: self-checking bench for multu_seq with a behavioural ripple-ALU model
module tb_multu_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nvec = 0;
    int   nfail = 0;
    int   done_cnt = 0;
    multu_seq_if #(.WIDTH(32)) bus();
    multu_seq #(.WIDTH(32), .ADD_CTL(6'd32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // ALU: adds only on the add control code
    assign {bus.alu_carry, bus.alu_result} = (bus.alu_ctl == 6'd32)
        ? {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 33'(bus.alu_cin) : 33'd0;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (!reset) begin
            check("alu_ctl_cin", {57'd0, bus.alu_ctl, bus.alu_cin}, {57'd0, 6'd32, 1'b0});
            if (!bus.busy) check("alu_idle_zero", {bus.alu_a, bus.alu_b}, 64'd0);
        end
    end
    // Issue a request and step to the done cycle (bounded); optionally inject a
    // full-scale start at RUN cycle inj.
    task automatic go(input logic [31:0] a, input logic [31:0] b, input int inj,
                      output int cyc, output int bcnt);
        bus.start = 1'b1;
        bus.dataA = a;
        bus.dataB = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        bcnt = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) bcnt++;
            if (cyc == inj) begin
                bus.start = 1'b1;
                bus.dataA = '1;
                bus.dataB = '1;
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
    endtask
    initial begin
        vec_t vt[6];
        int cyc, bcnt, d0;
        logic [31:0] ra, rb;
        logic [63:0] ref_p;
        vt[0] = '{32'd3, 32'd5, 32'h0, 32'h0000000F};
        vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[2] = '{32'h80000000, 32'd2, 32'h00000001, 32'h0};
        vt[3] = '{32'h12345678, 32'd0, 32'h0, 32'h0};
        vt[4] = '{32'd0, 32'hDEADBEEF, 32'h0, 32'h0};
        vt[5] = '{32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'hFFFE0001};
        bus.start = 1'b0;
        bus.dataA = '0;
        bus.dataB = '0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.dataA = '1;
        bus.dataB = '1;
        @(negedge clk);
        check("reset_state", {bus.hi, bus.lo, 30'd0, bus.busy, bus.done}, 96'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {62'd0, bus.busy, bus.done}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            go(vt[i].a, vt[i].b, 0, cyc, bcnt);
            check($sformatf("vec%0d_done_cycle", i), 64'(cyc), 64'd33);
            check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd32);
            check($sformatf("vec%0d_product", i), {bus.hi, bus.lo}, {vt[i].hi, vt[i].lo});
            @(negedge clk);
            check($sformatf("vec%0d_done_once", i), 64'(done_cnt - d0), 64'd1);
            check($sformatf("vec%0d_hold", i), {bus.hi, bus.lo}, {vt[i].hi, vt[i].lo});
        end
        // start ignored in RUN and in DONE
        d0 = done_cnt;
        go(32'd7, 32'd9, 10, cyc, bcnt);
        check("ign_done_cycle", 64'(cyc), 64'd33);
        check("ign_product", {bus.hi, bus.lo}, 64'd63);
        bus.start = 1'b1;
        bus.dataA = '1;
        bus.dataB = '1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("ign_idle_busy", {63'd0, bus.busy}, 64'd0);
        check("ign_hold", {bus.hi, bus.lo}, 64'd63);
        check("ign_done_once", 64'(done_cnt - d0), 64'd1);
        // reset in the middle of a run
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.dataA = 32'hFFFF;
        bus.dataB = 32'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("mid_busy_before_reset", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_state", {bus.hi, bus.lo, 30'd0, bus.busy, bus.done}, 96'd0);
        repeat (40) @(negedge clk);
        check("mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("mid_still_idle", {bus.hi, bus.lo, 31'd0, bus.busy}, 95'd0);
        go(32'd4, 32'd4, 0, cyc, bcnt);
        check("after_reset_cycle", 64'(cyc), 64'd33);
        check("after_reset_product", {bus.hi, bus.lo}, 64'd16);
        @(negedge clk);
        // back-to-back random against arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 10 == 0) ra = '1;
            ref_p = {32'd0, ra} * {32'd0, rb};
            go(ra, rb, 0, cyc, bcnt);
            check($sformatf("rnd%0d_cycle", i), 64'(cyc), 64'd33);
            check($sformatf("rnd%0d_%h_%h", i, ra, rb), {bus.hi, bus.lo}, ref_p);
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
